// File: rtl/bf16_pkg.sv
// Shared field widths, constants and types for the bfloat16 operand path.
package bf16_pkg;

  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned BF16_EXP_W = 8;
  localparam int unsigned BF16_MAN_W = 7;

  localparam logic [BF16_EXP_W-1:0] BF16_EXP_ONES = 8'hFF;
  // Mantissa of the canonical quiet NaN: only the quiet bit set.
  localparam logic [BF16_MAN_W-1:0] BF16_QNAN_MAN = 7'h40;

  typedef logic [15:0] bf16_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    SEND_B
  } feeder_state_t;

endpackage

// File: rtl/fp32_to_bf16_rne.sv
// Combinational FP32 -> bfloat16 conversion, round-to-nearest-even, denormals flushed.
module fp32_to_bf16_rne
  import bf16_pkg::*;
(
  input  logic [31:0] fp32,
  output bf16_t       bf16
);

  logic [FP32_EXP_W-1:0] exp_f;
  logic [FP32_MAN_W-1:0] man_f;
  logic                  round_up;
  logic [15:0]           rounded;

  // Classify the input and pick the matching encoding.
  always_comb begin
    exp_f    = fp32[30:23];
    man_f    = fp32[22:0];
    round_up = fp32[15] & ((|fp32[14:0]) | fp32[16]);
    // Carry may ripple into the exponent; largest finite rounds to inf.
    rounded  = fp32[31:16] + {15'd0, round_up};
    if (exp_f == BF16_EXP_ONES) begin
      if (man_f != '0) begin
        bf16 = {fp32[31], BF16_EXP_ONES, BF16_QNAN_MAN | {1'b0, fp32[21:16]}};
      end else begin
        bf16 = {fp32[31], BF16_EXP_ONES, 7'h00};
      end
    end else if (exp_f == '0) begin
      bf16 = {fp32[31], 15'h0000};
    end else begin
      bf16 = rounded;
    end
  end

endmodule

// File: rtl/bf16_operand_feeder.sv
// Converts FP32 operand pairs to bfloat16, queues them, and presents them to the
// adder: operand a sampled on the adder_ready cycle, operand b on the cycle after.
module bf16_operand_feeder
  import bf16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             adder_ready,
  output logic [15:0]      a_o,
  output logic [15:0]      b_o,
  output logic             issued,
  output logic             busy,
  output logic [CNT_W-1:0] pair_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  bf16_t            bf_a, bf_b;
  logic [31:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             push, pop, not_empty;
  feeder_state_t    state_q, state_d;
  bf16_t            a_q, b_q;
  logic [CNT_W-1:0] pair_count_q;

  fp32_to_bf16_rne u_cvt_a (
    .fp32 (in_a),
    .bf16 (bf_a)
  );

  fp32_to_bf16_rne u_cvt_b (
    .fp32 (in_b),
    .bf16 (bf_b)
  );

  // Handshake and pop decode; a pop happens whenever the output registers are free.
  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q < DEPTH_C) & ~reset;
    push      = in_valid & in_ready;
    pop       = not_empty & ((state_q == IDLE) | (state_q == SEND_B));
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bf_a, bf_b};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Presentation FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (not_empty) state_d = PRESENT;
      PRESENT: if (adder_ready) state_d = SEND_B;
      SEND_B:  state_d = not_empty ? PRESENT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand registers and issued-pair counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      pair_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        {a_q, b_q} <= fifo_q[rd_ptr_q];
      end
      if (state_q == SEND_B) begin
        pair_count_q <= pair_count_q + 1'b1;
      end
    end
  end

  // A pair cut short by reset is not reported as issued.
  always_comb begin
    a_o        = a_q;
    b_o        = b_q;
    pair_count = pair_count_q;
    issued     = (state_q == SEND_B) & ~reset;
    busy       = not_empty | (state_q != IDLE);
  end

endmodule

// File: tb/tb_bf16_operand_feeder.sv
// Directed self-checking bench for bf16_operand_feeder.
module tb_bf16_operand_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        adder_ready = 1'b0;
  logic [15:0] a_o, b_o;
  logic        issued, busy;
  logic [15:0] pair_count;

  int vectors = 0;
  int miscompares = 0;

  bf16_operand_feeder #(.DEPTH(4), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .adder_ready (adder_ready),
    .a_o         (a_o),
    .b_o         (b_o),
    .issued      (issued),
    .busy        (busy),
    .pair_count  (pair_count)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; adder_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Offer one pair until accepted, bounded.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 20) begin tick(); n++; end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Pulse adder_ready in PRESENT, then step through SEND_B.
  task automatic issue_one();
    adder_ready = 1'b1; tick();
    adder_ready = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if ({in_ready, a_o, b_o, issued, busy, pair_count} !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%0b a=%h b=%h iss=%0b busy=%0b cnt=%0d, required all 0",
               in_ready, a_o, b_o, issued, busy, pair_count);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_conversion();
    logic [31:0] va [7] = '{32'h3F800000, 32'h3F818000, 32'h7F7FFFFF, 32'h7F800001,
                            32'h00000000, 32'h4049_0FDB, 32'hC0A0_0000};
    logic [31:0] vb [7] = '{32'h3F808000, 32'h3F808001, 32'h80000001, 32'hFF800000,
                            32'h80000000, 32'h3F7F_8000, 32'h7FFF_FFFF};
    logic [15:0] ea [7] = '{16'h3F80, 16'h3F82, 16'h7F80, 16'h7FC0, 16'h0000, 16'h4049,
                            16'hC0A0};
    logic [15:0] eb [7] = '{16'h3F80, 16'h3F81, 16'h8000, 16'hFF80, 16'h8000, 16'h3F80,
                            16'h7FFF};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      push_pair(va[i], vb[i]);
      tick();
      vectors++;
      if (a_o !== ea[i] || b_o !== eb[i]) begin
        miscompares++;
        $display("FAIL convert[%0d]: a=%h b=%h, required a=%h b=%h", i, a_o, b_o, ea[i], eb[i]);
      end
      issue_one();
    end
    vectors++;
    if (pair_count !== 16'd7) begin
      miscompares++;
      $display("FAIL convert_count: pair_count=%0d, required 7", pair_count);
    end
  endtask

  task automatic test_handshake();
    apply_reset();
    adder_ready = 1'b1; tick(); adder_ready = 1'b0;
    vectors++;
    if (issued !== 1'b0 || busy !== 1'b0 || pair_count !== 16'd0) begin
      miscompares++;
      $display("FAIL idle_ready_ignored: iss=%0b busy=%0b cnt=%0d, required 0 0 0",
               issued, busy, pair_count);
    end
    push_pair(32'h4040_0000, 32'h4080_0000);
    vectors++;
    if (busy !== 1'b1 || a_o !== 16'h0000) begin
      miscompares++;
      $display("FAIL accept_latency: busy=%0b a=%h, required busy=1 a=0000", busy, a_o);
    end
    tick();
    vectors++;
    if (a_o !== 16'h4040 || b_o !== 16'h4080) begin
      miscompares++;
      $display("FAIL present: a=%h b=%h, required 4040 4080", a_o, b_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (issued !== 1'b0 || a_o !== 16'h4040) begin
        miscompares++;
        $display("FAIL present_hold[%0d]: iss=%0b a=%h, required 0 4040", i, issued, a_o);
      end
    end
    adder_ready = 1'b1; tick();
    vectors++;
    if (issued !== 1'b1 || pair_count !== 16'd0 || b_o !== 16'h4080) begin
      miscompares++;
      $display("FAIL send_b: iss=%0b cnt=%0d b=%h, required 1 0 4080", issued, pair_count, b_o);
    end
    tick();
    vectors++;
    if (issued !== 1'b0 || busy !== 1'b0 || pair_count !== 16'd1 || a_o !== 16'h4040) begin
      miscompares++;
      $display("FAIL after_issue: iss=%0b busy=%0b cnt=%0d a=%h, required 0 0 1 4040",
               issued, busy, pair_count, a_o);
    end
    tick();
    adder_ready = 1'b0;
    vectors++;
    if (issued !== 1'b0 || pair_count !== 16'd1) begin
      miscompares++;
      $display("FAIL idle_again: iss=%0b cnt=%0d, required 0 1", issued, pair_count);
    end
  endtask

  // Pair k converts to a = 3F80+k, b = 4000+k.
  task automatic test_back_pressure();
    int accepted = 0;
    int got = 0;
    int last = 0;
    int cyc = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_a = {16'h3F80 + 16'(accepted), 16'h0000};
      in_b = {16'h4000 + 16'(accepted), 16'h0000};
      if (in_ready) accepted++;
      tick();
    end
    vectors++;
    if (accepted !== 5 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: accepted=%0d in_ready=%0b, required 5 0", accepted, in_ready);
    end
    adder_ready = 1'b1;
    while (got < 6 && cyc < 60) begin
      in_valid = (accepted < 6);
      in_a = {16'h3F80 + 16'(accepted), 16'h0000};
      in_b = {16'h4000 + 16'(accepted), 16'h0000};
      if (in_valid && in_ready) accepted++;
      tick(); cyc++;
      if (issued) begin
        vectors++;
        if (a_o !== 16'h3F80 + 16'(got) || b_o !== 16'h4000 + 16'(got) ||
            (got > 0 && cyc - last != 2)) begin
          miscompares++;
          $display("FAIL drain[%0d]: a=%h b=%h gap=%0d, required a=%h b=%h gap=2", got, a_o,
                   b_o, cyc - last, 16'h3F80 + 16'(got), 16'h4000 + 16'(got));
        end
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    tick();
    adder_ready = 1'b0;
    vectors++;
    if (got !== 6 || pair_count !== 16'd6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_total: got=%0d cnt=%0d busy=%0b, required 6 6 0", got, pair_count,
               busy);
    end
  endtask

  // Push in SEND_B at occupancy 2; order and exact occupancy are seen by draining.
  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 3; k++) push_pair({16'h4100 + 16'(k), 16'h0}, {16'h4200 + 16'(k), 16'h0});
    adder_ready = 1'b1; tick(); adder_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h4103_0000; in_b = 32'h4203_0000;
    vectors++;
    if (issued !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_setup: iss=%0b rdy=%0b, required 1 1", issued, in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (a_o !== 16'h4100 + 16'(k) || b_o !== 16'h4200 + 16'(k)) begin
        miscompares++;
        $display("FAIL simul_order[%0d]: a=%h b=%h, required %h %h", k, a_o, b_o,
                 16'h4100 + 16'(k), 16'h4200 + 16'(k));
      end
      issue_one();
    end
    vectors++;
    if (busy !== 1'b0 || pair_count !== 16'd4) begin
      miscompares++;
      $display("FAIL simul_end: busy=%0b cnt=%0d, required 0 4", busy, pair_count);
    end
  endtask

  // 12 pairs through a depth-4 FIFO with irregular adder_ready; reference queue.
  task automatic test_wrap();
    logic [31:0] exp_q [$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [31:0] e;
    apply_reset();
    while (got < 12 && cyc < 300) begin
      in_valid = (sent < 12);
      in_a = {16'h4500 + 16'(sent), 16'h0000};
      in_b = {16'hC600 + 16'(sent), 16'h7FFF};
      adder_ready = (cyc % 3 != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({16'h4500 + 16'(sent), 16'hC600 + 16'(sent)});
        sent++;
      end
      tick(); cyc++;
      if (issued) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        vectors++;
        if ({a_o, b_o} !== e) begin
          miscompares++;
          $display("FAIL wrap[%0d]: got %h, required %h", got, {a_o, b_o}, e);
        end
        got++;
      end
    end
    in_valid = 1'b0; adder_ready = 1'b0;
    tick();
    vectors++;
    if (got !== 12 || pair_count !== 16'd12 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_total: got=%0d cnt=%0d busy=%0b, required 12 12 0", got, pair_count,
               busy);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 4; k++) push_pair({16'h4700 + 16'(k), 16'h0}, {16'h4800 + 16'(k), 16'h0});
    adder_ready = 1'b1; tick(); adder_ready = 1'b0;
    vectors++;
    if (issued !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: issued=%0b, required 1", issued);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (a_o !== 16'h0 || b_o !== 16'h0 || issued !== 1'b0 || busy !== 1'b0 ||
        pair_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: a=%h b=%h iss=%0b busy=%0b cnt=%0d, required all 0", a_o, b_o,
               issued, busy, pair_count);
    end
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if (busy !== 1'b0 || pair_count !== 16'd0 || in_ready !== 1'b1 || a_o !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_after: busy=%0b cnt=%0d rdy=%0b a=%h, required 0 0 1 0000", busy,
               pair_count, in_ready, a_o);
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_handshake();
    test_back_pressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
